// File: rtl/line_buffer_3x3.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_3x3
// Description : Raster-stream 3x3 window generator built from two line memories.
//               It emits only windows that lie fully inside the image.
//               Optional macro LB_SOF_EN adds sof_i, which forces the accepted
//               pixel to position (0,0).
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
`ifdef LB_SOF_EN
    input  logic       sof_i,
`endif
    input  logic [7:0] pix_i,
    output logic [7:0] data_o_0,
    output logic [7:0] data_o_1,
    output logic [7:0] data_o_2,
    output logic [7:0] data_o_3,
    output logic [7:0] data_o_4,
    output logic [7:0] data_o_5,
    output logic [7:0] data_o_6,
    output logic [7:0] data_o_7,
    output logic [7:0] data_o_8,
    output logic       valid_o
);

    localparam int c_CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_HEIGHT - 1);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
    localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);

    localparam logic [0:0] c_ST_FILL   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic [0:0]      r_state;
    logic            r_valid;
    logic [7:0]      r_win [9];
    logic [7:0]      r_lb1 [IMG_WIDTH];
    logic [7:0]      r_lb2 [IMG_WIDTH];

    logic            w_sof;
    logic [c_CW-1:0] w_col;
    logic [c_RW-1:0] w_row;
    logic [0:0]      w_state;
    logic [0:0]      w_state_nxt;
    logic            w_col_last;
    logic            w_row_last;
    logic [7:0]      w_top;
    logic [7:0]      w_mid;

`ifdef LB_SOF_EN
    assign w_sof = sof_i;
`else
    assign w_sof = 1'b0;
`endif

    // Effective position/state of the pixel being accepted; a start-of-frame
    // marker overrides the tracked position so every downstream decision agrees.
    always_comb begin
        w_col      = w_sof ? '0 : r_col;
        w_row      = w_sof ? '0 : r_row;
        w_state    = w_sof ? c_ST_FILL : r_state;
        w_col_last = (w_col == c_COL_LAST);
        w_row_last = (w_row == c_ROW_LAST);
        w_top      = r_lb2[w_col];
        w_mid      = r_lb1[w_col];
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            c_ST_FILL:   if (w_col_last && (w_row == c_ROW_ONE)) w_state_nxt = c_ST_ACTIVE;
            c_ST_ACTIVE: if (w_col_last && w_row_last)           w_state_nxt = c_ST_FILL;
            default:     w_state_nxt = c_ST_FILL;
        endcase
    end

    // Line memories carry no reset: every entry is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (en_i && !rst) begin
            r_lb2[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= pix_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= c_ST_FILL;
            r_valid <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_valid <= en_i && (w_state == c_ST_ACTIVE) && (w_col >= c_COL_TWO);
            if (en_i) begin
                r_state <= w_state_nxt;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : (w_row + c_RW'(1));
                end else begin
                    r_col <= w_col + c_CW'(1);
                    r_row <= w_row;
                end
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_top;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_mid;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pix_i;
            end
        end
    end

    assign data_o_0 = r_win[0];
    assign data_o_1 = r_win[1];
    assign data_o_2 = r_win[2];
    assign data_o_3 = r_win[3];
    assign data_o_4 = r_win[4];
    assign data_o_5 = r_win[5];
    assign data_o_6 = r_win[6];
    assign data_o_7 = r_win[7];
    assign data_o_8 = r_win[8];
    assign valid_o  = r_valid;

endmodule
`default_nettype wire

// File: doc/line_buffer_3x3.md
LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (legal range 4..4096).
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame (legal range 3..4096).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port en_i  input  1  pixel valid; pix_i accepted on any rising edge with en_i=1.
REQ-006 Port pix_i  input  8  raster-order pixel, line by line, left to right.
REQ-007 Port data_o_0..data_o_8  output  8 each  3x3 window, row-major: data_o_0 = (r-2,c-2), data_o_4 = (r-1,c-1) centre, data_o_8 = (r,c) newest.
REQ-008 Port valid_o  output  1  window on data_o_* is complete and inside the image; drives en_i of the downstream gauss stage.

Function
REQ-009 Column counter col shall increment on each accepted pixel and wrap IMG_WIDTH-1 -> 0; row counter row shall increment on that wrap and wrap IMG_HEIGHT-1 -> 0 (frame end).
REQ-010 Two line memories LB1 and LB2, each IMG_WIDTH x 8 bit, indexed by col: on accept, LB2[col] <= LB1[col], LB1[col] <= pix_i.
REQ-011 On accept, the 3x3 window shall shift one column left and load the new right column {top, mid, bottom} = {LB2[col], LB1[col], pix_i}, using pre-update memory values.
REQ-012 State machine FILL / ACTIVE: FILL while row < 2; FILL -> ACTIVE on the accept that takes row to 2; ACTIVE -> FILL on the accept of the last pixel of the frame (row IMG_HEIGHT-1, col IMG_WIDTH-1).
REQ-013 valid_o shall be 1 in the cycle after an accept where the state is ACTIVE (or the accept enters ACTIVE is false: row==2 entry pixel has col 0, so not valid) and the accepted pixel's col >= 2; otherwise 0.
REQ-014 Latency: one clock from accepting pixel (r,c) to data_o_8 = that pixel with valid_o=1.
REQ-015 en_i=0: counters, memories, window and state hold; valid_o = 0 the next cycle.
REQ-016 Columns 0 and 1 of every line and rows 0 and 1 of every frame shall never produce valid_o; windows never straddle a line or frame boundary; no padding.
REQ-017 Exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) valid_o pulses per frame.
REQ-018 Back-to-back frames with en_i continuously 1 shall be supported with no idle cycle.

Reset
REQ-019 rst=1 shall immediately set col=0, row=0, state=FILL, valid_o=0, all data_o_* = 0x00.
REQ-020 Line memory contents are not cleared; they are overwritten before use.
REQ-021 Reset mid-frame shall abandon the frame; the first accepted pixel after release is (0,0).
REQ-022 While rst=1, en_i shall be ignored.

Configuration
REQ-023 Macro LB_SOF_EN: when defined, input port sof_i (1 bit) is present; an accept with sof_i=1 shall treat pix_i as pixel (0,0), forcing col/row to that position, state to FILL, and valid_o to 0 next cycle.
REQ-024 Without LB_SOF_EN, sof_i is absent and position is tracked by counters alone.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pix = row*16+col)
REQ-025 Reset release, stream 16 pixels with en_i=1 -> first valid_o one cycle after pixel 0x22, data_o_0..8 = 00,01,02,10,11,12,20,21,22.
REQ-026 Same frame -> exactly 4 valid_o pulses, with data_o_8 = 0x22, 0x23, 0x32, 0x33; none after pixels 0x30 or 0x31.
REQ-027 en_i toggled 1/0 every cycle during the frame -> identical 4 windows, valid_o never high in the cycle after en_i=0.
REQ-028 Two frames back-to-back, second with pix + 0x80 -> second frame's first window data_o_0 = 0x80, data_o_8 = 0xA2; no window mixes frames.
REQ-029 rst asserted after pixel 0x21, then a full frame -> valid_o and data_o_* at 0 during reset; the next frame produces 4 correct windows.
REQ-030 With LB_SOF_EN: sof_i=1 on the pixel following 0x12 -> that pixel is treated as (0,0); the next 4 windows match REQ-026 relative to the new frame start.
